unary_stream_gen: RTL and testbench
===================================

Name: unary_stream_gen

Overview:
- Binary-to-unary bitstream encoder. Converts a BITWIDTH-bit binary value into a 2^BITWIDTH-cycle bitstream that contains exactly that many 1s.
- It is the producer end of the unary datapath. A downstream counting accumulator summing oBit over one stream recovers the original value exactly.
- Two codings are supported: temporal (thermometer) and deterministic rate coding (bit-reversed counter comparison).

Parameters:
- BITWIDTH, 8, width of the input value. The stream length is 2^BITWIDTH cycles.

Ports:
- iClk  input  1  clock; all state updates on the rising edge.
- iRst  input  1  synchronous, active-high reset.
- iEn  input  1  advance enable; low stalls the stream with state held.
- iClr  input  1  synchronous abort to IDLE.
- iValid  input  1  load request.
- iData  input  BITWIDTH  binary value to encode.
- iMode  input  1  coding select: 0 = temporal, 1 = rate.
- oReady  output  1  load accepted this cycle when iValid && oReady.
- oBit  output  1  unary stream bit.
- oBitValid  output  1  oBit is a stream bit this cycle.
- oLast  output  1  marks the final (2^BITWIDTH-th) bit of a stream.

Behaviour:
- Clock and reset: one clock, iClk. Reset is synchronous and active-high. Reset iRst samples on the iClk rising edge and has top priority: state=IDLE, cnt=0, value=0, mode=0. Reset mid-stream discards the stream with no oLast.
- Output reset values: while iRst is high and after reset, oReady=0 during iRst, then 1 in IDLE; oBit=0, oBitValid=0, oLast=0.
- State: FSM with states IDLE and RUN. Registers: cnt (BITWIDTH bits), value (BITWIDTH bits), mode (1 bit).
- oReady (combinational): !iRst && !iClr && (IDLE || (RUN && iEn && cnt==2^BITWIDTH-1)).
- Accept: iValid && oReady latches value<=iData, mode<=iMode, cnt<=0, state<=RUN. iData and iMode are ignored at all other times.
- Latency: the first stream bit appears the cycle after accept.
- RUN outputs (combinational from registers): oBitValid = iEn.
  - mode 0: oBit = (cnt < value).
  - mode 1: oBit = (value > bitrev(cnt)), where bitrev reverses the BITWIDTH bits of cnt.
  - oLast = iEn && cnt==2^BITWIDTH-1.
  - Outside RUN, oBit, oBitValid and oLast are 0.
- RUN advance: with iEn=1, cnt increments. At cnt==2^BITWIDTH-1 it wraps to 0 and the FSM goes to IDLE, or stays in RUN with a new value if a load is accepted that same cycle. This gives gapless back-to-back streams.
- Stall: iEn=0 holds cnt, value and state; oBitValid=0.
- Ones count: both modes emit exactly value 1s per stream, since bitrev is a permutation.
  - value=0 gives all zeros.
  - Maximum is 2^BITWIDTH-1 ones; the bit at cnt==2^BITWIDTH-1 is 0 in temporal mode.
- iClr: state<=IDLE, cnt<=0. value and mode are held but irrelevant. The current stream is aborted without oLast, and oReady=0 that cycle, so no load occurs.
- Simultaneous events, in priority order: iRst, then iClr, then last-bit-with-accept, then accept, then advance.
- Arithmetic: cnt compares are unsigned; cnt wraps modulo 2^BITWIDTH.

Test Plan:
- BITWIDTH=4, iMode=0, load 5 with iEn=1 -> oBitValid for 16 cycles; oBit = 1 for cycles 1-5 after accept, 0 for cycles 6-16; oLast only on cycle 16; oReady returns to 1.
- iMode=1, load 8 -> oBit alternates 1,0,1,0,… over 16 cycles, 8 ones total. Load 3 -> ones at cnt 0, 8, 4 only.
- Boundary values, both modes -> load 0 gives 0 ones; load 15 gives 15 ones, and in temporal mode the bit at cnt 15 is 0.
- Stall: temporal load 10, drop iEn for 3 cycles at cnt 4 -> oBitValid low for 3 cycles, cnt held, and the stream completes with exactly 10 ones and one oLast.
- Back-to-back: hold iValid with 7 then 2 -> second accept happens on the oLast cycle of the first, with no gap; 32 contiguous valid bits counted as 7 + 2 ones.
- Abort and reset: iClr at cnt 6 -> IDLE next cycle, no oLast, oReady=0 during iClr. iRst mid-stream -> all outputs 0 and the next load starts fresh at cnt 0.

Source files
------------

// File: rtl/unary_stream_gen.sv
// Binary-to-unary stream encoder: a BITWIDTH-bit value becomes a 2^BITWIDTH-bit
// stream with exactly that many ones, in thermometer or bit-reversed rate coding.
//
// state | meaning
// IDLE  | no stream in flight, ready to accept a load
// RUN   | emitting one stream bit per enabled cycle
module unary_stream_gen #(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iClr,
  input  logic                iValid,
  input  logic [BITWIDTH-1:0] iData,
  input  logic                iMode,
  output logic                oReady,
  output logic                oBit,
  output logic                oBitValid,
  output logic                oLast
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              r_state;
  logic [BITWIDTH-1:0] r_cnt;
  logic [BITWIDTH-1:0] r_value;
  logic                r_mode;

  state_t              w_state_nxt;
  logic [BITWIDTH-1:0] w_cnt_nxt;
  logic [BITWIDTH-1:0] w_value_nxt;
  logic                w_mode_nxt;
  logic [BITWIDTH-1:0] w_cnt_rev;
  logic                w_cnt_max;
  logic                w_run;
  logic                w_accept;

  assign w_cnt_max = (r_cnt == {BITWIDTH{1'b1}});
  assign w_run     = (r_state == RUN);

  always_comb begin
    w_cnt_rev = '0;
    for (int k = 0; k < BITWIDTH; k++) begin
      w_cnt_rev[k] = r_cnt[BITWIDTH-1-k];
    end
  end

  // A load is only possible from IDLE or on the final bit, giving gapless streams.
  assign oReady   = !iRst && !iClr && ((r_state == IDLE) || (w_run && iEn && w_cnt_max));
  assign w_accept = iValid && oReady;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_value_nxt = r_value;
    w_mode_nxt  = r_mode;
    if (iClr) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (w_accept) begin
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
      w_value_nxt = iData;
      w_mode_nxt  = iMode;
    end else if (w_run && iEn) begin
      w_cnt_nxt = r_cnt + BITWIDTH'(1);
      if (w_cnt_max) begin
        w_state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_value <= '0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_value <= w_value_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  // Outputs are forced quiet while reset is asserted, even if a stream was in flight.
  always_comb begin
    oBit      = 1'b0;
    oBitValid = 1'b0;
    oLast     = 1'b0;
    if (w_run && !iRst) begin
      oBitValid = iEn;
      oBit      = r_mode ? (r_value > w_cnt_rev) : (r_cnt < r_value);
      oLast     = iEn && w_cnt_max;
    end
  end

endmodule

// File: tb/tb_unary_stream_gen.sv
// Directed bench for unary_stream_gen at BITWIDTH=4 (16-bit streams).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_unary_stream_gen;

  localparam int BW = 4;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iEn;
  logic          iClr;
  logic          iValid;
  logic [BW-1:0] iData;
  logic          iMode;
  logic          oReady;
  logic          oBit;
  logic          oBitValid;
  logic          oLast;

  int checks   = 0;
  int failures = 0;

  unary_stream_gen #(.BITWIDTH(BW)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iEn       (iEn),
    .iClr      (iClr),
    .iValid    (iValid),
    .iData     (iData),
    .iMode     (iMode),
    .oReady    (oReady),
    .oBit      (oBit),
    .oBitValid (oBitValid),
    .oLast     (oLast)
  );

  always #5 iClk = ~iClk;

  // Loads val/mode and records 16 cycles of output with iEn held high.
  task automatic run_stream(input logic [BW-1:0] val, input logic mode,
                            output logic [15:0] bits, output int nvalid,
                            output logic [15:0] lastv, output logic rdy);
    @(posedge iClk); #1;
    iValid = 1'b1; iData = val; iMode = mode; iEn = 1'b1;
    @(negedge iClk);
    rdy = oReady;
    @(posedge iClk); #1;
    iValid = 1'b0; iData = '0;
    bits = '0; lastv = '0; nvalid = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge iClk);
      bits[i]  = oBit;
      lastv[i] = oLast;
      if (oBitValid) nvalid++;
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1; iEn = 1'b0; iClr = 1'b0; iValid = 1'b0; iData = '0; iMode = 1'b0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    checks++;
    if ({oReady, oBit, oBitValid, oLast} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000", {oReady, oBit, oBitValid, oLast});
    end
    @(posedge iClk); #1;
    iRst = 1'b0;
    @(negedge iClk);
    checks++;
    if ({oReady, oBit, oBitValid, oLast} !== 4'b1000) begin
      failures++;
      $display("FAIL idle_outputs got=%b want=1000", {oReady, oBit, oBitValid, oLast});
    end
  endtask

  task automatic test_temporal();
    logic [15:0] bits, lastv;
    int nv;
    logic rdy;
    run_stream(4'd5, 1'b0, bits, nv, lastv, rdy);
    checks++;
    if (rdy !== 1'b1) begin failures++; $display("FAIL temporal_ready got=%b want=1", rdy); end
    checks++;
    if (bits !== 16'h001F) begin failures++; $display("FAIL temporal5_bits got=%h want=001f", bits); end
    checks++;
    if (nv !== 16) begin failures++; $display("FAIL temporal5_valid got=%0d want=16", nv); end
    checks++;
    if (lastv !== 16'h8000) begin failures++; $display("FAIL temporal5_last got=%h want=8000", lastv); end
    @(negedge iClk);
    checks++;
    if ({oReady, oBitValid} !== 2'b10) begin
      failures++;
      $display("FAIL temporal5_after got=%b want=10", {oReady, oBitValid});
    end
  endtask

  task automatic test_rate();
    logic [15:0] bits, lastv;
    int nv;
    logic rdy;
    run_stream(4'd8, 1'b1, bits, nv, lastv, rdy);
    checks++;
    if (bits !== 16'h5555) begin failures++; $display("FAIL rate8_bits got=%h want=5555", bits); end
    checks++;
    if (lastv !== 16'h8000) begin failures++; $display("FAIL rate8_last got=%h want=8000", lastv); end
    run_stream(4'd3, 1'b1, bits, nv, lastv, rdy);
    checks++;
    if (bits !== 16'h0111) begin failures++; $display("FAIL rate3_bits got=%h want=0111", bits); end
  endtask

  task automatic test_boundary();
    logic [15:0] bits, lastv;
    int nv;
    logic rdy;
    run_stream(4'd0, 1'b0, bits, nv, lastv, rdy);
    checks++;
    if (bits !== 16'h0000) begin failures++; $display("FAIL temporal0_bits got=%h want=0000", bits); end
    run_stream(4'd0, 1'b1, bits, nv, lastv, rdy);
    checks++;
    if (bits !== 16'h0000) begin failures++; $display("FAIL rate0_bits got=%h want=0000", bits); end
    run_stream(4'd15, 1'b0, bits, nv, lastv, rdy);
    checks++;
    if (bits !== 16'h7FFF) begin failures++; $display("FAIL temporal15_bits got=%h want=7fff", bits); end
    run_stream(4'd15, 1'b1, bits, nv, lastv, rdy);
    checks++;
    if ($countones(bits) !== 15) begin
      failures++;
      $display("FAIL rate15_ones got=%0d want=15", $countones(bits));
    end
  endtask

  task automatic test_stall();
    logic [15:0] vbits;
    int nv, ninv, nlast, last_idx;
    @(posedge iClk); #1;
    iValid = 1'b1; iData = 4'd10; iMode = 1'b0; iEn = 1'b1;
    @(posedge iClk); #1;
    iValid = 1'b0;
    vbits = '0; nv = 0; ninv = 0; nlast = 0; last_idx = -1;
    for (int i = 0; i < 19; i++) begin
      if (i > 0) begin
        @(posedge iClk); #1;
      end
      iEn = !(i >= 4 && i <= 6);
      @(negedge iClk);
      if (oBitValid) begin
        if (nv < 16) vbits[nv] = oBit;
        nv++;
      end else begin
        ninv++;
      end
      if (oLast) begin nlast++; last_idx = i; end
    end
    iEn = 1'b1;
    checks++;
    if (ninv !== 3) begin failures++; $display("FAIL stall_gap got=%0d want=3", ninv); end
    checks++;
    if (vbits !== 16'h03FF || nv !== 16) begin
      failures++;
      $display("FAIL stall_bits got=%h/%0d want=03ff/16", vbits, nv);
    end
    checks++;
    if (nlast !== 1 || last_idx !== 18) begin
      failures++;
      $display("FAIL stall_last got=%0d@%0d want=1@18", nlast, last_idx);
    end
  endtask

  task automatic test_back_to_back();
    int nv, ones;
    logic [31:0] lastv;
    logic rdy_mid, rdy_last;
    @(posedge iClk); #1;
    iValid = 1'b1; iData = 4'd7; iMode = 1'b0; iEn = 1'b1;
    @(posedge iClk); #1;
    iData = 4'd2;
    nv = 0; ones = 0; lastv = '0; rdy_mid = 1'b0; rdy_last = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) begin
        @(posedge iClk); #1;
        if (i == 16) iValid = 1'b0;
      end
      @(negedge iClk);
      if (oBitValid) nv++;
      if (oBitValid && oBit) ones++;
      lastv[i] = oLast;
      if (i == 7) rdy_mid = oReady;
      if (i == 15) rdy_last = oReady;
    end
    checks++;
    if (rdy_mid !== 1'b0 || rdy_last !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready got=%b%b want=01", rdy_mid, rdy_last);
    end
    checks++;
    if (nv !== 32 || ones !== 9) begin
      failures++;
      $display("FAIL b2b_stream got=%0d/%0d want=32/9", nv, ones);
    end
    checks++;
    if (lastv !== 32'h8000_8000) begin
      failures++;
      $display("FAIL b2b_last got=%h want=80008000", lastv);
    end
  endtask

  task automatic test_abort_reset();
    logic [15:0] bits, lastv;
    int nv, nlast;
    logic rdy;
    @(posedge iClk); #1;
    iValid = 1'b1; iData = 4'd10; iMode = 1'b0; iEn = 1'b1;
    @(posedge iClk); #1;
    iValid = 1'b0;
    nlast = 0;
    repeat (6) begin
      @(negedge iClk);
      if (oLast) nlast++;
      @(posedge iClk); #1;
    end
    iClr = 1'b1; iValid = 1'b1; iData = 4'd3;
    @(negedge iClk);
    checks++;
    if ({oReady, oLast} !== 2'b00) begin
      failures++;
      $display("FAIL clr_cycle got=%b want=00", {oReady, oLast});
    end
    @(posedge iClk); #1;
    iClr = 1'b0; iValid = 1'b0;
    @(negedge iClk);
    checks++;
    if ({oReady, oBitValid, oLast} !== 3'b100 || nlast !== 0) begin
      failures++;
      $display("FAIL clr_idle got=%b lasts=%0d want=100 lasts=0", {oReady, oBitValid, oLast}, nlast);
    end
    @(posedge iClk); #1;
    iValid = 1'b1; iData = 4'd12; iMode = 1'b1;
    @(posedge iClk); #1;
    iValid = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    iRst = 1'b1;
    @(negedge iClk);
    checks++;
    if ({oReady, oBit, oBitValid, oLast} !== 4'b0000) begin
      failures++;
      $display("FAIL rst_mid got=%b want=0000", {oReady, oBit, oBitValid, oLast});
    end
    @(posedge iClk); #1;
    iRst = 1'b0;
    @(negedge iClk);
    checks++;
    if ({oReady, oBitValid} !== 2'b10) begin
      failures++;
      $display("FAIL rst_idle got=%b want=10", {oReady, oBitValid});
    end
    run_stream(4'd5, 1'b0, bits, nv, lastv, rdy);
    checks++;
    if (bits !== 16'h001F || lastv !== 16'h8000) begin
      failures++;
      $display("FAIL rst_fresh got=%h/%h want=001f/8000", bits, lastv);
    end
  endtask

  initial begin
    test_reset();
    test_temporal();
    test_rate();
    test_boundary();
    test_stall();
    test_back_to_back();
    test_abort_reset();
    repeat (2) @(posedge iClk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
